// File: rtl/mem_responder.sv
// mem_responder: main-memory model serving line refills and writebacks one word per cycle after a fixed latency
`ifndef CACHE_B
`define CACHE_B 6
`endif
module mem_responder #(
  parameter int OFFSET_WIDTH = `CACHE_B,
  parameter int MEM_DEPTH    = 1024,
  parameter int LATENCY      = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] read_data_o,
  output logic        data_valid_o,
  output logic        busy_o,
  output logic        done_o
);
  localparam int WW = OFFSET_WIDTH - 2;
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;
  state_t          state, state_nx;
  logic [31:0]     base;
  logic            we_q;
  logic [CW-1:0]   lat;
  logic [WW-1:0]   k;
  logic [31:0]     mem [MEM_DEPTH];
  logic [AW-1:0]   idx;
  logic            xfer;
  assign xfer         = state == XFER;
  assign busy_o       = state != IDLE;
  assign done_o       = state == DONE;
  assign data_valid_o = xfer;
  assign mem_addr_o   = xfer ? base + 32'({k, 2'b00}) : base;
  assign idx          = mem_addr_o[AW+1:2];
  assign read_data_o  = (xfer && !we_q) ? mem[idx] : '0;
  // next-state: accept in IDLE, count latency, stream W words, one-cycle DONE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_i ? WAIT : IDLE;
      WAIT:    state_nx = (lat == CW'(1)) ? XFER : WAIT;
      XFER:    state_nx = (k == '1) ? DONE : XFER;
      default: state_nx = IDLE;
    endcase
  end
  // state, latched request and counters; reset abandons any transaction in flight
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      base  <= '0;
      we_q  <= 1'b0;
      lat   <= '0;
      k     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_i) begin
        base <= addr_i & ~((32'd1 << OFFSET_WIDTH) - 32'd1);
        we_q <= we_i;
        lat  <= CW'(LATENCY);
      end
      if (state == WAIT) begin
        lat <= lat - CW'(1);
        k   <= '0;
      end
      if (xfer) k <= k + WW'(1);
    end
  end
  // backing array is not reset so contents survive a reset
  always_ff @(posedge clk_i) begin
    if (xfer && we_q) mem[idx] <= write_data_i;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vector and sequence checks of mem_responder (W=4, LATENCY=3)
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] mem_addr, rdata;
  logic        valid, busy, done;
  int          checks = 0, errors = 0;
  typedef struct {
    logic        req, we;
    logic [31:0] addr, wd, ea, er;
    logic        ev, eb, ed;
  } vec_t;
  vec_t tbl [19];
  mem_responder #(.OFFSET_WIDTH(4), .MEM_DEPTH(1024), .LATENCY(3)) dut (
    .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .write_data_i(wdata), .mem_addr_o(mem_addr), .read_data_o(rdata),
    .data_valid_o(valid), .busy_o(busy), .done_o(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic vec_t mk(input logic r, w, input logic [31:0] a, wd, ea, er, input logic ev, eb, ed);
    vec_t v;
    v.req = r; v.we = w; v.addr = a; v.wd = wd; v.ea = ea; v.er = er;
    v.ev = ev; v.eb = eb; v.ed = ed;
    return v;
  endfunction
  task automatic xact(input logic w, input logic [31:0] a, input logic [3:0][31:0] d);
    req = 1'b1; we = w; addr = a;
    @(posedge clk);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      req = 1'b0;
      if (c >= 4 && c <= 7) wdata = d[c-4];
      #1;
      chk("x_valid", 32'(valid), 32'(c >= 4 && c <= 7));
      chk("x_busy", 32'(busy), 32'(c <= 8));
      chk("x_done", 32'(done), 32'(c == 8));
      chk("x_addr", mem_addr, (a & ~32'hF) + ((c >= 4 && c <= 7) ? 32'((c - 4) * 4) : 32'd0));
      chk("x_rdata", rdata, (!w && c >= 4 && c <= 7) ? d[c-4] : 32'd0);
    end
  endtask
  initial begin
    logic [3:0][31:0] d;
    tbl[0] = mk(1, 1, 32'h40, 0, 32'h0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) tbl[i] = mk(0, 1, 32'h40, 0, 32'h40, 0, 0, 1, 0);
    for (int i = 4; i <= 7; i++) tbl[i] = mk(0, 1, 32'h40, 32'hA0 + 32'(i - 4), 32'h40 + 32'(4 * (i - 4)), 0, 1, 1, 0);
    tbl[8] = mk(0, 1, 32'h40, 0, 32'h40, 0, 0, 1, 1);
    tbl[9] = mk(1, 0, 32'h4C, 0, 32'h40, 0, 0, 0, 0);
    for (int i = 10; i <= 12; i++) tbl[i] = mk(1, 1, 32'hFFF0, 32'h55, 32'h40, 0, 0, 1, 0);
    for (int i = 13; i <= 16; i++) tbl[i] = mk(0, 1, 32'hFFF0, 32'h55, 32'h40 + 32'(4 * (i - 13)), 32'hA0 + 32'(i - 13), 1, 1, 0);
    tbl[17] = mk(0, 0, 32'h0, 0, 32'h40, 0, 0, 1, 1);
    tbl[18] = mk(0, 0, 32'h0, 0, 32'h40, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      req = tbl[i].req; we = tbl[i].we; addr = tbl[i].addr; wdata = tbl[i].wd;
      #1;
      chk($sformatf("t%0d_addr", i), mem_addr, tbl[i].ea);
      chk($sformatf("t%0d_rdata", i), rdata, tbl[i].er);
      chk($sformatf("t%0d_valid", i), 32'(valid), 32'(tbl[i].ev));
      chk($sformatf("t%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
      chk($sformatf("t%0d_done", i), 32'(done), 32'(tbl[i].ed));
    end
    for (int i = 0; i < 4; i++) d[i] = 32'hB0 + 32'(i);
    xact(1'b1, 32'h80, d);
    req = 1'b1; we = 1'b1; addr = 32'h80;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      req = 1'b0;
      if (c >= 4) wdata = 32'hDEAD_0000 + 32'(c - 4);
    end
    @(negedge clk);
    wdata = 32'hDEAD_0002;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      chk("post_rst_done", 32'(done), 0);
      chk("post_rst_busy", 32'(busy), 0);
    end
    d[0] = 32'hDEAD_0000; d[1] = 32'hDEAD_0001; d[2] = 32'hB2; d[3] = 32'hB3;
    xact(1'b0, 32'h80, d);
    for (int i = 0; i < 4; i++) d[i] = 32'h11 + 32'(i);
    xact(1'b1, 32'h1000, d);
    xact(1'b0, 32'h0, d);
    req = 1'b1; we = 1'b0; addr = 32'h1000;
    @(posedge clk);
    for (int c = 1; c <= 27; c++) begin
      int m;
      m = c % 9;
      @(negedge clk);
      #1;
      chk("hold_valid", 32'(valid), 32'(m >= 4 && m <= 7));
      chk("hold_busy", 32'(busy), 32'(m != 0));
      chk("hold_done", 32'(done), 32'(m == 8));
      chk("hold_rdata", rdata, (m >= 4 && m <= 7) ? d[m-4] : 32'd0);
    end
    req = 1'b0;
    @(negedge clk);
    #1 chk("hold_stop_busy", 32'(busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
